// File: rtl/reg_dump_ctrl.sv
// Read-side dump initiator: walks an inclusive, wrapping address range on the
// register bank's read port and streams address-tagged words with a running checksum.
module reg_dump_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] rd_addr_d, out_addr_d;
  logic [DATA_W-1:0] out_data_d, checksum_d;
  logic              out_valid_d, busy_d, done_d;

  // Checksum accumulation deliberately drops the carry out of the top bit.
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rd_addr_d   = rd_addr;
    out_valid_d = out_valid;
    out_addr_d  = out_addr;
    out_data_d  = out_data;
    busy_d      = busy;
    done_d      = 1'b0;
    checksum_d  = checksum;
    case (state_q)
      IDLE: begin
        if (start) begin
          last_d     = last_addr;
          rd_addr_d  = first_addr;
          checksum_d = '0;
          busy_d     = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        out_data_d  = rd_data;
        out_addr_d  = rd_addr;
        checksum_d  = add_wrap(checksum, rd_data);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_addr == last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Address increment wraps naturally at the bank depth.
            rd_addr_d = rd_addr + ADDR_W'(1);
            state_d   = READ;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rd_addr   <= rd_addr_d;
      out_valid <= out_valid_d;
      out_addr  <= out_addr_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
      done      <= done_d;
      checksum  <= checksum_d;
    end
  end

endmodule
